// File: rtl/lsu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_unit : multi-cycle load/store unit, one word-aligned request/response |
// |            transaction per op with byte-lane steering and load extension. |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [3:0]        mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic                wen_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          wmask_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [1:0]          off_d;
  logic                misal_d;
  logic [3:0]          wmask_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [DATA_W-1:0]   shifted_d;
  logic [DATA_W-1:0]   load_d;

  // Lane steering is computed from the incoming op so the bus fields are
  // registered once at accept and stay stable for the whole request.
  always_comb begin
    off_d   = in_addr[1:0];
    misal_d = 1'b0;
    wmask_d = 4'b0000;
    wdata_d = '0;
    case (in_size)
      2'b00: begin
        wmask_d = 4'b0001 << off_d;
        wdata_d = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        misal_d = off_d[0];
        wmask_d = 4'b0011 << off_d;
        wdata_d = {2{in_wdata[15:0]}};
      end
      default: begin
        misal_d = (off_d != 2'b00);
        wmask_d = 4'b1111;
        wdata_d = in_wdata;
      end
    endcase
    if (!in_wen) begin
      wmask_d = 4'b0000;
      wdata_d = '0;
    end
  end

  always_comb begin
    shifted_d = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_d = {{(DATA_W-8){shifted_d[7] & ~uns_q}}, shifted_d[7:0]};
      2'b01:   load_d = {{(DATA_W-16){shifted_d[15] & ~uns_q}}, shifted_d[15:0]};
      default: load_d = shifted_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wmask_q <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            wen_q   <= in_wen;
            size_q  <= in_size;
            uns_q   <= in_unsigned;
            addr_q  <= in_addr;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            if (misal_d) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            rdata_q <= wen_q ? '0 : load_d;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wen       = wen_q;
  assign mem_wmask     = wmask_q;
  assign mem_wdata     = wdata_q;
  assign out_valid     = (state_q == S_DONE);
  assign rdata         = rdata_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_unit : directed self-checking bench for lsu_unit                   |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wen = 1'b0;
  logic [1:0]  in_size = 2'b00;
  logic        in_unsigned = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int failures = 0;

  lsu_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  // Drives one op and plays the bus; lat counts cycles from the accept cycle.
  task automatic do_op(
    input  logic wen, input logic [1:0] size, input logic uns,
    input  logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
    input  int stall, input bit noisy,
    output int lat, output int nreq,
    output logic [31:0] a, output logic [3:0] m, output logic [31:0] w,
    output logic we, output bit unstable, output bit rdy_busy,
    output logic [31:0] r, output logic e);
    bit hs;
    int stall_left;
    lat = -1; nreq = 0; a = '0; m = '0; w = '0; we = 1'b0;
    unstable = 1'b0; rdy_busy = 1'b0; r = '0; e = 1'b0;
    hs = 1'b0; stall_left = stall;
    @(negedge clk);
    in_valid = 1'b1; in_wen = wen; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wd; mem_req_ready = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = c; r = rdata; e = err;
        break;
      end
      if (in_ready) rdy_busy = 1'b1;
      if (mem_req_valid) begin
        if (nreq == 0) begin
          a = mem_addr; m = mem_wmask; w = mem_wdata; we = mem_wen;
        end else if (a !== mem_addr || m !== mem_wmask || w !== mem_wdata || we !== mem_wen) begin
          unstable = 1'b1;
        end
        nreq++;
        if (stall_left > 0) begin
          stall_left--; mem_req_ready = 1'b0;
        end else begin
          mem_req_ready = 1'b1; hs = 1'b1;
        end
        mem_resp_valid = noisy;
        mem_rdata = 32'h5A5A_C3C3;
      end else if (hs) begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = rd;
      end else begin
        mem_resp_valid = 1'b0;
      end
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({mem_req_valid, out_valid, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {mem_req_valid, out_valid, err}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (mem_addr !== 32'h0 || mem_wmask !== 4'h0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", mem_addr, mem_wmask); end
  endtask

  task automatic test_word_load();
    int lat, nreq; logic [31:0] a, w, r; logic [3:0] m; logic we, e; bit un, rb;
    do_op(1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 1'b0,
          lat, nreq, a, m, w, we, un, rb, r, e);
    checks++; if (a !== 32'h8000_0004) begin failures++; $display("FAIL wl_addr got=%h exp=80000004", a); end
    checks++; if ({we, m} !== 5'b0 || w !== 32'h0) begin failures++; $display("FAIL wl_bus got=%b/%h/%h exp=0/0/0", we, m, w); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL wl_latency got=%0d exp=3", lat); end
    checks++; if (r !== 32'hDEAD_BEEF || e !== 1'b0) begin failures++; $display("FAIL wl_rdata got=%h err=%b exp=deadbeef err=0", r, e); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL wl_pulse got=%b/%b exp=0/1", out_valid, in_ready); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wl_hold got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_subword_load();
    int lat, nreq; logic [31:0] a, w, r; logic [3:0] m; logic we, e; bit un, rb;
    logic [1:0]  sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic        us  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ad  [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002, 32'h8000_0000, 32'h8000_0001};
    logic [31:0] exp [6] = '{32'h0000_0080, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_0011, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, sz[i], us[i], ad[i], 32'h0, 32'h80FF_0011, 0, 1'b0,
            lat, nreq, a, m, w, we, un, rb, r, e);
      checks++; if (r !== exp[i] || lat !== 3 || e !== 1'b0) begin failures++; $display("FAIL subload_%0d got=%h lat=%0d err=%b exp=%h lat=3 err=0", i, r, lat, e, exp[i]); end
      checks++; if (a !== {ad[i][31:2], 2'b00}) begin failures++; $display("FAIL subload_addr_%0d got=%h exp=%h", i, a, {ad[i][31:2], 2'b00}); end
    end
  endtask

  task automatic test_store();
    int lat, nreq; logic [31:0] a, w, r; logic [3:0] m; logic we, e; bit un, rb;
    logic [1:0]  sz  [3] = '{2'b00, 2'b01, 2'b11};
    logic [31:0] ad  [3] = '{32'h8000_0102, 32'h8000_0206, 32'h8000_0308};
    logic [31:0] wd  [3] = '{32'h1234_56AB, 32'h1234_5678, 32'hCAFE_F00D};
    logic [31:0] ea  [3] = '{32'h8000_0100, 32'h8000_0204, 32'h8000_0308};
    logic [3:0]  em  [3] = '{4'b0100, 4'b1100, 4'b1111};
    logic [31:0] ew  [3] = '{32'hABAB_ABAB, 32'h5678_5678, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, sz[i], 1'b0, ad[i], wd[i], 32'hFFFF_FFFF, 0, 1'b0,
            lat, nreq, a, m, w, we, un, rb, r, e);
      checks++; if (a !== ea[i] || m !== em[i] || w !== ew[i] || we !== 1'b1) begin failures++; $display("FAIL store_bus_%0d got=%h/%b/%h/%b exp=%h/%b/%h/1", i, a, m, w, we, ea[i], em[i], ew[i]); end
      checks++; if (r !== 32'h0 || e !== 1'b0 || lat !== 3) begin failures++; $display("FAIL store_done_%0d got=%h err=%b lat=%0d exp=0 err=0 lat=3", i, r, e, lat); end
    end
  endtask

  task automatic test_misaligned();
    int lat, nreq; logic [31:0] a, w, r; logic [3:0] m; logic we, e; bit un, rb;
    do_op(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0, 32'h1111_1111, 0, 1'b0,
          lat, nreq, a, m, w, we, un, rb, r, e);
    checks++; if (nreq !== 0) begin failures++; $display("FAIL mis_word_req got=%0d exp=0", nreq); end
    checks++; if (lat !== 1 || e !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL mis_word got lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=0", lat, e, r); end
    do_op(1'b1, 2'b01, 1'b0, 32'h8000_0003, 32'h0, 32'h1111_1111, 0, 1'b0,
          lat, nreq, a, m, w, we, un, rb, r, e);
    checks++; if (nreq !== 0 || lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL mis_half got req=%0d lat=%0d err=%b exp req=0 lat=1 err=1", nreq, lat, e); end
    @(negedge clk);
    checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL mis_hold got err=%b ov=%b exp err=1 ov=0", err, out_valid); end
  endtask

  task automatic test_backpressure();
    int lat, nreq; logic [31:0] a, w, r; logic [3:0] m; logic we, e; bit un, rb;
    do_op(1'b0, 2'b10, 1'b0, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, 3, 1'b1,
          lat, nreq, a, m, w, we, un, rb, r, e);
    checks++; if (nreq !== 4 || un !== 1'b0 || a !== 32'h8000_0040) begin failures++; $display("FAIL bp_stable got req=%0d unstable=%b addr=%h exp req=4 unstable=0 addr=80000040", nreq, un, a); end
    checks++; if (rb !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", rb); end
    checks++; if (lat !== 6) begin failures++; $display("FAIL bp_latency got=%0d exp=6", lat); end
    checks++; if (r !== 32'h0BAD_F00D || e !== 1'b0) begin failures++; $display("FAIL bp_rdata got=%h err=%b exp=0badf00d err=0", r, e); end
  endtask

  task automatic test_reset_in_wait();
    int lat, nreq; logic [31:0] a, w, r; logic [3:0] m; logic we, e; bit un, rb;
    bit saw_ov;
    saw_ov = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_wen = 1'b0; in_size = 2'b10; in_addr = 32'h8000_0010;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    checks++; if (mem_req_valid !== 1'b0 || in_ready !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL rst_wait_state got req=%b rdy=%b rdata=%h exp 0/1/0", mem_req_valid, in_ready, rdata); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
    end
    mem_resp_valid = 1'b0;
    checks++; if (saw_ov !== 1'b0) begin failures++; $display("FAIL rst_wait_no_out got=%b exp=0", saw_ov); end
    do_op(1'b0, 2'b00, 1'b0, 32'h8000_0011, 32'h0, 32'h0000_FE00, 0, 1'b0,
          lat, nreq, a, m, w, we, un, rb, r, e);
    checks++; if (r !== 32'hFFFF_FFFE || lat !== 3 || a !== 32'h8000_0010) begin failures++; $display("FAIL rst_wait_next got=%h lat=%0d addr=%h exp=fffffffe lat=3 addr=80000010", r, lat, a); end
  endtask

  task automatic test_back_to_back();
    int lat, nreq; logic [31:0] a, w, r; logic [3:0] m; logic we, e; bit un, rb;
    do_op(1'b1, 2'b10, 1'b0, 32'h8000_0020, 32'h0102_0304, 32'h0, 0, 1'b1,
          lat, nreq, a, m, w, we, un, rb, r, e);
    checks++; if (lat !== 3 || m !== 4'hF || w !== 32'h0102_0304 || rb !== 1'b0) begin failures++; $display("FAIL b2b_first got lat=%0d mask=%h wdata=%h rdybusy=%b exp 3/f/01020304/0", lat, m, w, rb); end
    do_op(1'b0, 2'b01, 1'b1, 32'h8000_0022, 32'h0, 32'hA5A5_0000, 0, 1'b1,
          lat, nreq, a, m, w, we, un, rb, r, e);
    checks++; if (lat !== 3 || r !== 32'h0000_A5A5 || nreq !== 1) begin failures++; $display("FAIL b2b_second got lat=%0d rdata=%h req=%0d exp 3/0000a5a5/1", lat, r, nreq); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_store();
    test_misaligned();
    test_word_load();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
